// File: rtl/ball_tracker.sv
// Ball position/direction owner for pong: steps on divided tick, reflects off walls and paddles.
// Latency: pos, hit/miss pulses and state update on the step edge; plate decodes pos with zero latency.
// No backpressure: tick/serve are single-cycle enables, serve is ignored while a rally is in play.
module ball_tracker #(
    parameter int WIDTH        = 16,
    parameter int BIT_OF_WIDTH = 4,
    parameter int PADDLE_LEN   = 4,
    parameter int STEP_DIV     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      serve,
    input  logic                      serve_dir,
    input  logic [BIT_OF_WIDTH-1:0]   paddle_l_y,
    input  logic [BIT_OF_WIDTH-1:0]   paddle_r_y,
    output logic [2*BIT_OF_WIDTH-1:0] pos,
    output logic [3:0]                plate,
    output logic                      hit_l,
    output logic                      hit_r,
    output logic                      miss_l,
    output logic                      miss_r,
    output logic                      busy
);
    localparam int BW = BIT_OF_WIDTH;
    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [BW-1:0] CENTER   = BW'(WIDTH / 2);
    localparam logic [BW-1:0] LO       = BW'(1);
    localparam logic [BW-1:0] HI       = BW'(WIDTH - 2);
    localparam logic [BW-1:0] LAST     = BW'(WIDTH - 1);
    localparam logic [BW-1:0] RET_L    = BW'(2);
    localparam logic [BW-1:0] RET_R    = BW'(WIDTH - 3);
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [BW:0]   PLEN     = (BW + 1)'(PADDLE_LEN);

    typedef enum logic [1:0] {IDLE, PLAY, MISS} state_t;

    state_t         state;
    logic [BW-1:0]  x, y;
    logic           dx, dy;
    logic [DW-1:0]  div;

    logic           ndy;
    logic [BW-1:0]  ny;
    logic           in_l, in_r, at_l, at_r;

    // Paddle span compared one bit wider so a paddle near the bottom clips instead of wrapping.
    always_comb begin
        ndy = dy;
        if (y == LO && !dy) ndy = 1'b1;
        if (y == HI && dy)  ndy = 1'b0;
        ny   = ndy ? y + 1'b1 : y - 1'b1;
        in_l = ({1'b0, y} >= {1'b0, paddle_l_y}) && ({1'b0, y} < {1'b0, paddle_l_y} + PLEN);
        in_r = ({1'b0, y} >= {1'b0, paddle_r_y}) && ({1'b0, y} < {1'b0, paddle_r_y} + PLEN);
        at_l = (x == LO) && !dx;
        at_r = (x == HI) && dx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            x      <= CENTER;
            y      <= CENTER;
            dx     <= 1'b1;
            dy     <= 1'b1;
            div    <= '0;
            hit_l  <= 1'b0;
            hit_r  <= 1'b0;
            miss_l <= 1'b0;
            miss_r <= 1'b0;
        end else begin
            hit_l  <= 1'b0;
            hit_r  <= 1'b0;
            miss_l <= 1'b0;
            miss_r <= 1'b0;
            case (state)
                IDLE, MISS: begin
                    if (serve) begin
                        state <= PLAY;
                        x     <= CENTER;
                        y     <= CENTER;
                        dx    <= serve_dir;
                        dy    <= 1'b1;
                        div   <= '0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (div != DIV_LAST) begin
                            div <= div + DW'(1);
                        end else begin
                            div <= '0;
                            if (at_l) begin
                                if (in_l) begin
                                    dx    <= 1'b1;
                                    x     <= RET_L;
                                    y     <= ny;
                                    dy    <= ndy;
                                    hit_l <= 1'b1;
                                end else begin
                                    x      <= '0;
                                    miss_l <= 1'b1;
                                    state  <= MISS;
                                end
                            end else if (at_r) begin
                                if (in_r) begin
                                    dx    <= 1'b0;
                                    x     <= RET_R;
                                    y     <= ny;
                                    dy    <= ndy;
                                    hit_r <= 1'b1;
                                end else begin
                                    x      <= LAST;
                                    miss_r <= 1'b1;
                                    state  <= MISS;
                                end
                            end else begin
                                x  <= dx ? x + 1'b1 : x - 1'b1;
                                y  <= ny;
                                dy <= ndy;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pos   = {x, y};
    assign plate = {y == LO, y == HI, (state != MISS) && (x == LO), (state != MISS) && (x == HI)};
    assign busy  = (state == PLAY);

endmodule

// File: tb/tb_ball_tracker.sv
// Bench for ball_tracker: directed rally scenarios plus random play against a geometric reference model.
// Two instances (STEP_DIV 1 and 3) share stimulus; every cycle both are compared to their model.
module tb_ball_tracker;
    localparam int W  = 16;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       serve = 1'b0;
    logic       serve_dir = 1'b1;
    logic [3:0] paddle_l_y = '0;
    logic [3:0] paddle_r_y = '0;

    logic [7:0] pos_a, pos_b;
    logic [3:0] plate_a, plate_b;
    logic       hl_a, hr_a, ml_a, mr_a, busy_a;
    logic       hl_b, hr_b, ml_b, mr_b, busy_b;

    always #5 clk = ~clk;

    ball_tracker #(.WIDTH(W), .BIT_OF_WIDTH(4), .PADDLE_LEN(PL), .STEP_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .serve(serve), .serve_dir(serve_dir),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .pos(pos_a), .plate(plate_a),
        .hit_l(hl_a), .hit_r(hr_a), .miss_l(ml_a), .miss_r(mr_a), .busy(busy_a)
    );

    ball_tracker #(.WIDTH(W), .BIT_OF_WIDTH(4), .PADDLE_LEN(PL), .STEP_DIV(3)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .serve(serve), .serve_dir(serve_dir),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .pos(pos_b), .plate(plate_b),
        .hit_l(hl_b), .hit_r(hr_b), .miss_l(ml_b), .miss_r(mr_b), .busy(busy_b)
    );

    logic [16:0] out_a, out_b;
    assign out_a = {pos_a, plate_a, hl_a, hr_a, ml_a, mr_a, busy_a};
    assign out_b = {pos_b, plate_b, hl_b, hr_b, ml_b, mr_b, busy_b};

    // st: 0 idle, 1 in rally, 2 after a miss; directions are +1/-1 integers
    typedef struct {
        int x, y, dx, dy, div, st;
        bit hl, hr, ml, mr;
    } mdl_t;

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit covers(int row, int top);
        return (row >= top) && (row < top + PL);
    endfunction

    function automatic mdl_t mnext(mdl_t m, int sdiv, bit r, bit t, bit s, bit sd, int pl, int pr);
        mdl_t n = m;
        int   ndy, tx, p;
        n.hl = 0; n.hr = 0; n.ml = 0; n.mr = 0;
        if (r) begin
            n.x = W / 2; n.y = W / 2; n.dx = 1; n.dy = 1; n.div = 0; n.st = 0;
            return n;
        end
        if (m.st != 1) begin
            if (s) begin
                n.st = 1; n.x = W / 2; n.y = W / 2; n.dx = sd ? 1 : -1; n.dy = 1; n.div = 0;
            end
            return n;
        end
        if (!t) return n;
        if (m.div < sdiv - 1) begin
            n.div = m.div + 1;
            return n;
        end
        n.div = 0;
        ndy = m.dy;
        if ((m.y == 1 && m.dy < 0) || (m.y == W - 2 && m.dy > 0)) ndy = -m.dy;
        tx = m.x + m.dx;
        if (tx == 0 || tx == W - 1) begin
            p = (tx == 0) ? pl : pr;
            if (covers(m.y, p)) begin
                n.x = m.x - m.dx; n.dx = -m.dx; n.y = m.y + ndy; n.dy = ndy;
                if (tx == 0) n.hl = 1; else n.hr = 1;
            end else begin
                n.x = tx; n.st = 2;
                if (tx == 0) n.ml = 1; else n.mr = 1;
            end
        end else begin
            n.x = tx; n.y = m.y + ndy; n.dy = ndy;
        end
        return n;
    endfunction

    function automatic logic [16:0] mexp(mdl_t m);
        logic [3:0] xb, yb;
        xb = 4'(m.x);
        yb = 4'(m.y);
        return {xb, yb, m.y == 1, m.y == W - 2, (m.st != 2) && (m.x == 1), (m.st != 2) && (m.x == W - 2),
                m.hl, m.hr, m.ml, m.mr, m.st == 1};
    endfunction

    task automatic step_all();
        mdl_t na, nb;
        na = mnext(ma, 1, rst, tick, serve, serve_dir, int'(paddle_l_y), int'(paddle_r_y));
        nb = mnext(mb, 3, rst, tick, serve, serve_dir, int'(paddle_l_y), int'(paddle_r_y));
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        chk("out_a", 32'(out_a), 32'(mexp(ma)));
        chk("out_b", 32'(out_b), 32'(mexp(mb)));
    endtask

    task automatic cyc(input bit t, input bit s);
        tick  = t;
        serve = s;
        step_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_pos", 32'(pos_a), 32'h88);
        chk("rst_plate", 32'(plate_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_pulses", 32'({hl_a, hr_a, ml_a, mr_a}), 32'h0);

        // right paddle return
        paddle_l_y = 4'd0; paddle_r_y = 4'd12; serve_dir = 1'b1;
        cyc(0, 1);
        chk("serve_busy", 32'(busy_a), 32'h1);
        repeat (6) cyc(1, 0);
        chk("rh_pos6", 32'(pos_a), 32'hEE);
        chk("rh_plate6", 32'(plate_a), 32'b0101);
        cyc(1, 0);
        chk("rh_hit", 32'(hr_a), 32'h1);
        chk("rh_pos7", 32'(pos_a), 32'hDD);
        cyc(1, 0);
        chk("rh_pulse_1cyc", 32'(hr_a), 32'h0);

        // reset in the middle of a rally
        rst = 1'b1;
        cyc(1, 1);
        rst = 1'b0;
        chk("mid_rst_pos", 32'(pos_a), 32'h88);
        chk("mid_rst_busy", 32'(busy_a), 32'h0);
        chk("mid_rst_pulses", 32'({hl_a, hr_a, ml_a, mr_a}), 32'h0);

        // right miss, then position frozen
        paddle_r_y = 4'd0;
        cyc(0, 1);
        repeat (6) cyc(1, 0);
        cyc(1, 0);
        chk("rm_miss", 32'(mr_a), 32'h1);
        chk("rm_pos", 32'(pos_a), 32'hFE);
        chk("rm_busy", 32'(busy_a), 32'h0);
        repeat (3) cyc(1, 0);
        chk("rm_hold", 32'(pos_a), 32'hFE);

        // left return with wall flip, served straight from the miss state
        serve_dir = 1'b0; paddle_l_y = 4'd10;
        cyc(0, 1);
        repeat (7) cyc(1, 0);
        chk("lh_pos7", 32'(pos_a), 32'h1D);
        cyc(1, 0);
        chk("lh_hit", 32'(hl_a), 32'h1);
        chk("lh_pos8", 32'(pos_a), 32'h2C);

        // serve during play must not recenter or redirect
        cyc(0, 1);
        chk("srv_ign_hold", 32'(pos_a), 32'h2C);
        cyc(1, 1);
        chk("srv_ign_step", 32'(pos_a), 32'h3B);

        // paddle clipped at the bottom edge
        do_reset();
        paddle_r_y = 4'd14; serve_dir = 1'b1;
        cyc(0, 1);
        repeat (7) cyc(1, 0);
        chk("clip_hit", 32'(hr_a), 32'h1);
        chk("clip_hit_pos", 32'(pos_a), 32'hDD);
        do_reset();
        paddle_r_y = 4'd15;
        cyc(0, 1);
        repeat (7) cyc(1, 0);
        chk("clip_miss", 32'(mr_a), 32'h1);

        // divided stepping on the STEP_DIV=3 instance
        do_reset();
        paddle_r_y = 4'd0; serve_dir = 1'b1;
        cyc(0, 1);
        cyc(1, 0);
        cyc(1, 0);
        chk("div_c2", 32'(pos_b), 32'h88);
        cyc(1, 0);
        chk("div_c3", 32'(pos_b), 32'h99);
        cyc(1, 0);
        cyc(1, 0);
        chk("div_c5", 32'(pos_b), 32'h99);
        cyc(1, 0);
        chk("div_c6", 32'(pos_b), 32'hAA);

        // random play
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            serve_dir  = 1'($urandom);
            paddle_l_y = 4'($urandom);
            paddle_r_y = 4'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
